// File: rtl/csr_file_pkg.sv
// Shared CSR constants, write-port payload and write-decode helpers for csr_file.
package csr_file_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  typedef logic [CSR_AW-1:0] csr_addr_t;
  typedef logic [XLEN-1:0]   csr_data_t;

  typedef struct packed {
    logic      we;
    csr_addr_t addr;
    csr_data_t data;
  } csr_wr_t;

  localparam csr_addr_t CSR_NOP       = 12'h000;
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_t CSR_INSTRET   = 12'hC02;
  localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam csr_data_t MSTATUS_WMASK = (XLEN'(1) << MSTATUS_MIE) | (XLEN'(1) << MSTATUS_MPIE);
  localparam csr_data_t MSTATUS_MPP   = 32'h0000_1800;
  localparam csr_data_t MEPC_MASK     = 32'hFFFF_FFFC;

  // Only the machine-mode read/write CSRs accept writes; RO aliases and mhartid drop them.
  function automatic logic csr_writable(input csr_addr_t a);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_writable = 1'b1;
      default:                                              csr_writable = 1'b0;
    endcase
  endfunction

  // Value a write will read back as once stored.
  function automatic csr_data_t csr_wmask(input csr_addr_t a, input csr_data_t d);
    case (a)
      CSR_MSTATUS: csr_wmask = (d & MSTATUS_WMASK) | MSTATUS_MPP;
      CSR_MEPC:    csr_wmask = d & MEPC_MASK;
      default:     csr_wmask = d;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with per-half load; a load suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (we_lo) begin
      count[31:0] <= wdata;
    end else if (we_hi) begin
      count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: write port from mem, combinational read port to ex, trap/mret updates.
// Optional build macro CSR_BYPASS_EN forwards a same-cycle write to a matching read.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_csr_we,
  input  logic [11:0] mem_csr_waddr,
  input  logic [31:0] mem_csr_wdata,
  input  logic [11:0] ex_csr_raddr,
  output logic [31:0] ex_csr_rdata,
  output logic        ex_csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_we,
  input  logic [31:0] trap_mepc,
  input  logic [31:0] trap_mcause,
  input  logic        mret,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic        csr_mie_gl,
  output logic [31:0] csr_mie
);

  csr_wr_t   wr;
  logic      wr_ok;
  logic      mpie;
  csr_data_t mscratch;
  csr_data_t mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  csr_data_t mstatus_rd;

  assign wr    = '{we: mem_csr_we, addr: mem_csr_waddr, data: mem_csr_wdata};
  assign wr_ok = wr.we && csr_writable(wr.addr);

  // Trap entry beats mret beats a CSR write, per register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_mie_gl <= 1'b0;
      mpie       <= 1'b0;
      csr_mie    <= '0;
      csr_mtvec  <= MTVEC_RST;
      mscratch   <= '0;
      csr_mepc   <= '0;
      mcause     <= '0;
    end else begin
      if (trap_we) begin
        mpie       <= csr_mie_gl;
        csr_mie_gl <= 1'b0;
        csr_mepc   <= trap_mepc & MEPC_MASK;
        mcause     <= trap_mcause;
      end else begin
        if (mret) begin
          csr_mie_gl <= mpie;
          mpie       <= 1'b1;
        end else if (wr_ok && wr.addr == CSR_MSTATUS) begin
          csr_mie_gl <= wr.data[MSTATUS_MIE];
          mpie       <= wr.data[MSTATUS_MPIE];
        end
        if (wr_ok && wr.addr == CSR_MEPC)   csr_mepc <= wr.data & MEPC_MASK;
        if (wr_ok && wr.addr == CSR_MCAUSE) mcause   <= wr.data;
      end
      if (wr_ok && wr.addr == CSR_MIE)      csr_mie   <= wr.data;
      if (wr_ok && wr.addr == CSR_MTVEC)    csr_mtvec <= wr.data;
      if (wr_ok && wr.addr == CSR_MSCRATCH) mscratch  <= wr.data;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (wr_ok && wr.addr == CSR_MCYCLE),
    .we_hi (wr_ok && wr.addr == CSR_MCYCLEH),
    .wdata (wr.data),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .we_lo (wr_ok && wr.addr == CSR_MINSTRET),
    .we_hi (wr_ok && wr.addr == CSR_MINSTRETH),
    .wdata (wr.data),
    .count (minstret)
  );

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie, 3'b0, csr_mie_gl, 3'b0};

  // Read mux; unknown addresses read zero and flag illegal.
  always_comb begin
    ex_csr_rdata   = '0;
    ex_csr_illegal = 1'b0;
    case (ex_csr_raddr)
      CSR_MSTATUS:                ex_csr_rdata = mstatus_rd;
      CSR_MIE:                    ex_csr_rdata = csr_mie;
      CSR_MTVEC:                  ex_csr_rdata = csr_mtvec;
      CSR_MSCRATCH:               ex_csr_rdata = mscratch;
      CSR_MEPC:                   ex_csr_rdata = csr_mepc;
      CSR_MCAUSE:                 ex_csr_rdata = mcause;
      CSR_MCYCLE, CSR_CYCLE:      ex_csr_rdata = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    ex_csr_rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  ex_csr_rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: ex_csr_rdata = minstret[63:32];
      CSR_MHARTID:                ex_csr_rdata = HART_ID;
      default:                    ex_csr_illegal = 1'b1;
    endcase
`ifdef CSR_BYPASS_EN
    if (wr_ok && wr.addr == ex_csr_raddr) begin
      ex_csr_rdata   = csr_wmask(wr.addr, wr.data);
      ex_csr_illegal = 1'b0;
    end
`endif
  end

endmodule
